// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline boundary register carrying one opaque
// payload bus. With SKID=1 a second entry absorbs the beat that arrives while
// downstream stalls, so in_ready comes straight from a flop. With SKID=0 it is
// a single register whose in_ready is combinational. The low CTRL_W payload
// bits are control flags and are cleared whenever the stage holds no beat.
module pipe_stage_skid #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  // ones over the control field, zeros over the upper payload bits
  localparam logic [DATA_W-1:0] CTRL_MASK = {DATA_W{1'b1}} >> (DATA_W - CTRL_W);
  localparam logic [DATA_W-1:0] KEEP_MASK = ~CTRL_MASK;

  state_t            state;
  state_t            nstate;
  logic [DATA_W-1:0] mainq;
  logic [DATA_W-1:0] skidq;
  logic              rdyq;
  logic              in_fire;
  logic              out_fire;
  logic              loadmain;
  logic              loadskid;
  logic              skidtomain;

  assign out_valid = (state != EMPTY);
  assign out_data  = mainq;
  assign occupancy = state;

  // rdyq is reset to 1 so in_ready rises in the first cycle after reset;
  // the explicit reset term keeps in_ready low while reset is held
  assign in_ready = ~reset & ((SKID != 0) ? rdyq : (~out_valid | out_ready));

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // state register and the registered ready flag derived from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      rdyq  <= 1'b1;
    end else begin
      state <= nstate;
      rdyq  <= (nstate != FULL);
    end
  end

  // next-state and register-load decisions; flush overrides every transfer
  always_comb begin
    nstate     = state;
    loadmain   = 1'b0;
    loadskid   = 1'b0;
    skidtomain = 1'b0;
    unique case (state)
      EMPTY: begin
        if (in_fire) begin
          nstate   = BUSY;
          loadmain = 1'b1;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          loadmain = 1'b1;
        end else if (in_fire && (SKID != 0)) begin
          nstate   = FULL;
          loadskid = 1'b1;
        end else if (out_fire) begin
          nstate = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          nstate     = BUSY;
          skidtomain = 1'b1;
        end
      end
      default: begin
        nstate = EMPTY;
      end
    endcase
    if (flush) begin
      nstate     = EMPTY;
      loadmain   = 1'b0;
      loadskid   = 1'b0;
      skidtomain = 1'b0;
    end
  end

  // payload registers; control bits are cleared whenever an entry empties
  always_ff @(posedge clk) begin
    if (reset) begin
      mainq <= '0;
      skidq <= '0;
    end else begin
      if (loadmain) begin
        mainq <= in_data;
      end else if (skidtomain) begin
        mainq <= skidq;
      end else if (nstate == EMPTY) begin
        mainq <= mainq & KEEP_MASK;
      end
      if (loadskid) begin
        skidq <= in_data;
      end else if (nstate != FULL) begin
        skidq <= skidq & KEEP_MASK;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: drives a SKID=1 and a SKID=0 instance through directed
// vector tables, then through random traffic compared against a queue model.
module tb_pipe_stage_skid;

  localparam logic [63:0] KEEP = 64'hFFFF_FFFF_FFFF_FF00;

  typedef struct {
    logic        rst;
    logic        iv;
    logic        fl;
    logic        ordy;
    logic [63:0] din;
    logic        eir;
    logic        eov;
    logic [63:0] eod;
    logic [1:0]  eocc;
  } vec_t;

  logic clk;

  logic        rst1, ivalid1, iready1, flush1, ovalid1, oready1;
  logic [63:0] idata1, odata1;
  logic [1:0]  occ1;
  logic        rst0, ivalid0, iready0, flush0, ovalid0, oready0;
  logic [63:0] idata0, odata0;
  logic [1:0]  occ0;

  int total = 0;
  int bad   = 0;

  vec_t tab1[$];
  vec_t tab0[$];

  logic [63:0] q1[$];
  logic [63:0] q0[$];
  logic [63:0] last1 = 64'h0;
  logic [63:0] last0 = 64'h0;

  pipe_stage_skid #(.DATA_W(64), .CTRL_W(8), .SKID(1)) dut1 (
    .clk(clk), .reset(rst1), .in_valid(ivalid1), .in_ready(iready1),
    .in_data(idata1), .flush(flush1), .out_valid(ovalid1),
    .out_ready(oready1), .out_data(odata1), .occupancy(occ1)
  );

  pipe_stage_skid #(.DATA_W(64), .CTRL_W(8), .SKID(0)) dut0 (
    .clk(clk), .reset(rst0), .in_valid(ivalid0), .in_ready(iready0),
    .in_data(idata0), .flush(flush0), .out_valid(ovalid0),
    .out_ready(oready0), .out_data(odata0), .occupancy(occ0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic rst, input logic iv, input logic fl,
                              input logic ordy, input logic [63:0] din,
                              input logic eir, input logic eov,
                              input logic [63:0] eod, input logic [1:0] eocc);
    vec_t v;
    v.rst = rst; v.iv = iv; v.fl = fl; v.ordy = ordy; v.din = din;
    v.eir = eir; v.eov = eov; v.eod = eod; v.eocc = eocc;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input bit sel, input logic rst, input logic iv,
                               input logic fl, input logic ordy,
                               input logic [63:0] din);
    if (sel) begin
      rst1 = rst; ivalid1 = iv; flush1 = fl; oready1 = ordy; idata1 = din;
    end else begin
      rst0 = rst; ivalid0 = iv; flush0 = fl; oready0 = ordy; idata0 = din;
    end
  endtask

  task automatic runVec(input bit sel, input int idx, input vec_t v);
    @(negedge clk);
    applyStimulus(sel, v.rst, v.iv, v.fl, v.ordy, v.din);
    #1;
    if (sel) begin
      checkOutput($sformatf("t1[%0d] in_ready", idx), 64'(iready1), 64'(v.eir));
      checkOutput($sformatf("t1[%0d] out_valid", idx), 64'(ovalid1), 64'(v.eov));
      checkOutput($sformatf("t1[%0d] out_data", idx), odata1, v.eod);
      checkOutput($sformatf("t1[%0d] occupancy", idx), 64'(occ1), 64'(v.eocc));
    end else begin
      checkOutput($sformatf("t0[%0d] in_ready", idx), 64'(iready0), 64'(v.eir));
      checkOutput($sformatf("t0[%0d] out_valid", idx), 64'(ovalid0), 64'(v.eov));
      checkOutput($sformatf("t0[%0d] out_data", idx), odata0, v.eod);
      checkOutput($sformatf("t0[%0d] occupancy", idx), 64'(occ0), 64'(v.eocc));
    end
  endtask

  // reference: a FIFO of accepted beats, holding at most 2 (SKID=1) or 1 (SKID=0)
  task automatic stepModel(input bit sel, input int cyc, input logic iv,
                           input logic fl, input logic ordy, input logic [63:0] din,
                           input logic air, input logic aov,
                           input logic [63:0] aod, input logic [1:0] aocc);
    logic [63:0] q[$];
    logic [63:0] last;
    logic [63:0] eod;
    logic        eir;
    logic        ifire;
    logic        ofire;
    int          n;
    q    = sel ? q1 : q0;
    last = sel ? last1 : last0;
    n    = q.size();
    eir  = sel ? (n < 2) : ((n == 0) || ordy);
    eod  = (n > 0) ? q[0] : last;
    checkOutput($sformatf("rnd%0d[%0d] in_ready", sel, cyc), 64'(air), 64'(eir));
    checkOutput($sformatf("rnd%0d[%0d] out_valid", sel, cyc), 64'(aov), 64'(n > 0));
    checkOutput($sformatf("rnd%0d[%0d] out_data", sel, cyc), aod, eod);
    checkOutput($sformatf("rnd%0d[%0d] occupancy", sel, cyc), 64'(aocc), 64'(n));
    ofire = (n > 0) && ordy;
    ifire = iv && eir;
    if (fl) begin
      q.delete();
      last = eod & KEEP;
    end else begin
      if (ofire) void'(q.pop_front());
      if (ifire) q.push_back(din);
      if ((n > 0) && (q.size() == 0)) last = eod & KEEP;
    end
    if (sel) begin
      q1 = q; last1 = last;
    end else begin
      q0 = q; last0 = last;
    end
  endtask

  initial begin
    logic        iv1, fl1, or1, iv0, fl0, or0;
    logic [63:0] d1, d0;

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);

    // SKID=1: reset, stream, backpressure, bubble clear, flushes, reset mid-run
    tab1.push_back(mk(1, 0, 0, 0, 64'h0,                   0, 0, 64'h0,                   2'd0));
    tab1.push_back(mk(1, 0, 0, 0, 64'h0,                   0, 0, 64'h0,                   2'd0));
    tab1.push_back(mk(0, 1, 0, 1, 64'h10,                  1, 0, 64'h0,                   2'd0));
    tab1.push_back(mk(0, 1, 0, 1, 64'h11,                  1, 1, 64'h10,                  2'd1));
    tab1.push_back(mk(0, 1, 0, 1, 64'h12,                  1, 1, 64'h11,                  2'd1));
    tab1.push_back(mk(0, 0, 0, 1, 64'h0,                   1, 1, 64'h12,                  2'd1));
    tab1.push_back(mk(0, 0, 0, 0, 64'h0,                   1, 0, 64'h0,                   2'd0));
    tab1.push_back(mk(0, 1, 0, 0, 64'hA0,                  1, 0, 64'h0,                   2'd0));
    tab1.push_back(mk(0, 1, 0, 0, 64'hA1,                  1, 1, 64'hA0,                  2'd1));
    tab1.push_back(mk(0, 1, 0, 0, 64'hA2,                  0, 1, 64'hA0,                  2'd2));
    tab1.push_back(mk(0, 1, 0, 1, 64'hA2,                  0, 1, 64'hA0,                  2'd2));
    tab1.push_back(mk(0, 1, 0, 1, 64'hA2,                  1, 1, 64'hA1,                  2'd1));
    tab1.push_back(mk(0, 0, 0, 1, 64'h0,                   1, 1, 64'hA2,                  2'd1));
    tab1.push_back(mk(0, 0, 0, 0, 64'h0,                   1, 0, 64'h0,                   2'd0));
    tab1.push_back(mk(0, 1, 0, 0, 64'hDEAD_00FF,           1, 0, 64'h0,                   2'd0));
    tab1.push_back(mk(0, 0, 0, 1, 64'h0,                   1, 1, 64'hDEAD_00FF,           2'd1));
    tab1.push_back(mk(0, 0, 0, 0, 64'h0,                   1, 0, 64'hDEAD_0000,           2'd0));
    tab1.push_back(mk(0, 1, 0, 0, 64'hB0,                  1, 0, 64'hDEAD_0000,           2'd0));
    tab1.push_back(mk(0, 1, 0, 0, 64'hB1,                  1, 1, 64'hB0,                  2'd1));
    tab1.push_back(mk(0, 1, 1, 0, 64'hB2,                  0, 1, 64'hB0,                  2'd2));
    tab1.push_back(mk(0, 0, 0, 1, 64'h0,                   1, 0, 64'h0,                   2'd0));
    tab1.push_back(mk(0, 1, 0, 0, 64'h1234_5678,           1, 0, 64'h0,                   2'd0));
    tab1.push_back(mk(0, 1, 1, 1, 64'hC3,                  1, 1, 64'h1234_5678,           2'd1));
    tab1.push_back(mk(0, 0, 0, 1, 64'h0,                   1, 0, 64'h1234_5600,           2'd0));
    tab1.push_back(mk(0, 1, 0, 0, 64'hE0,                  1, 0, 64'h1234_5600,           2'd0));
    tab1.push_back(mk(0, 1, 0, 0, 64'hE1,                  1, 1, 64'hE0,                  2'd1));
    tab1.push_back(mk(1, 0, 0, 1, 64'h0,                   0, 1, 64'hE0,                  2'd2));
    tab1.push_back(mk(0, 0, 0, 1, 64'h0,                   1, 0, 64'h0,                   2'd0));

    // SKID=0: combinational ready, stall, simultaneous fire, flush, reset
    tab0.push_back(mk(1, 0, 0, 0, 64'h0,                   0, 0, 64'h0,                   2'd0));
    tab0.push_back(mk(0, 1, 0, 0, 64'h21,                  1, 0, 64'h0,                   2'd0));
    tab0.push_back(mk(0, 1, 0, 0, 64'h22,                  0, 1, 64'h21,                  2'd1));
    tab0.push_back(mk(0, 1, 0, 1, 64'h22,                  1, 1, 64'h21,                  2'd1));
    tab0.push_back(mk(0, 0, 0, 0, 64'h0,                   0, 1, 64'h22,                  2'd1));
    tab0.push_back(mk(0, 0, 0, 1, 64'h0,                   1, 1, 64'h22,                  2'd1));
    tab0.push_back(mk(0, 0, 0, 0, 64'h0,                   1, 0, 64'h0,                   2'd0));
    tab0.push_back(mk(0, 1, 0, 0, 64'hABCD_0155,           1, 0, 64'h0,                   2'd0));
    tab0.push_back(mk(0, 0, 1, 0, 64'h0,                   0, 1, 64'hABCD_0155,           2'd1));
    tab0.push_back(mk(0, 0, 0, 0, 64'h0,                   1, 0, 64'hABCD_0100,           2'd0));
    tab0.push_back(mk(1, 1, 0, 1, 64'h77,                  0, 0, 64'hABCD_0100,           2'd0));
    tab0.push_back(mk(0, 0, 0, 0, 64'h0,                   1, 0, 64'h0,                   2'd0));

    $display("[TB] directed vectors, SKID=1");
    for (int i = 0; i < tab1.size(); i++) runVec(1'b1, i, tab1[i]);
    $display("[TB] directed vectors, SKID=0");
    for (int i = 0; i < tab0.size(); i++) runVec(1'b0, i, tab0[i]);

    $display("[TB] random traffic against queue model");
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      iv1 = ($urandom_range(0, 3) != 0);
      or1 = ($urandom_range(0, 2) != 0);
      fl1 = ($urandom_range(0, 19) == 0);
      d1  = {$urandom, $urandom};
      iv0 = ($urandom_range(0, 3) != 0);
      or0 = ($urandom_range(0, 2) != 0);
      fl0 = ($urandom_range(0, 19) == 0);
      d0  = {$urandom, $urandom};
      applyStimulus(1'b1, 1'b0, iv1, fl1, or1, d1);
      applyStimulus(1'b0, 1'b0, iv0, fl0, or0, d0);
      #1;
      stepModel(1'b1, cyc, iv1, fl1, or1, d1, iready1, ovalid1, odata1, occ1);
      stepModel(1'b0, cyc, iv0, fl0, or0, d0, iready0, ovalid0, odata0, occ0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised successor to the fixed inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one opaque payload bus across a stage boundary using a valid/ready handshake.
- Optionally uses a 2-entry skid buffer so upstream ready is a registered signal.
- Supports synchronous flush, and zeroes control bits in bubbles.
- Is instantiated once per boundary. Stages pack their signals (PC, inst, RegWrite, MemRead, Rd, ...) into data.

Parameters:
DATA_W, 64, payload width in bits (>=1).
CTRL_W, 8, number of low payload bits (control flags: RegWrite/MemRead/MemWrite/CsrWrite...) forced to 0 whenever the stage holds no valid beat; 0 <= CTRL_W <= DATA_W.
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
clk  input  1  clock, all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  upstream beat valid.
in_ready  output  1  stage can accept a beat this cycle.
in_data  input  DATA_W  upstream payload.
flush  input  1  synchronous kill of all held beats (branch mispredict/trap).
out_valid  output  1  downstream beat valid.
out_ready  input  1  downstream accepts (0 = stall).
out_data  output  DATA_W  payload presented downstream.
occupancy  output  2  number of beats held (0..2; max 1 when SKID=0).

Behaviour:
- Fire rules: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset (reset=1 at edge):
  - state goes to EMPTY; main and skid registers go to 0.
  - out_valid=0, out_data=0, occupancy=0.
  - in_ready=0 while reset is high. It rises in the first cycle after reset deasserts.
- SKID=1 FSM: states EMPTY, BUSY (main full), FULL (main+skid full).
  - Outputs: in_ready = (state!=FULL), driven from a flop. out_valid = (state!=EMPTY). out_data = main.
  - EMPTY: in_fire -> BUSY, main<=in_data.
  - BUSY:
    - in_fire & out_fire -> BUSY, main<=in_data.
    - in_fire & !out_ready -> FULL, skid<=in_data.
    - !in_fire & out_fire -> EMPTY.
    - Neither -> hold.
  - FULL: out_fire -> BUSY, main<=skid. Otherwise hold. in_valid is ignored.
  - Latency: 1 cycle from in_fire to out_valid. Full throughput, 1 beat/cycle, with out_ready held high.
- SKID=0:
  - States are EMPTY and BUSY only.
  - in_ready = !out_valid | out_ready (combinational, 0 during reset).
  - in_fire loads main and sets BUSY. out_fire without in_fire goes to EMPTY.
- Ordering: beats leave in exact arrival order. No beat is dropped or duplicated except by flush/reset.
- Bubble clearing: on any transition into EMPTY (drain, flush, reset), main[CTRL_W-1:0] <= 0. Upper bits hold their last value, except on reset, which zeroes all bits. The skid CTRL bits are also zeroed when the skid empties.
- Flush (reset has priority over flush):
  - At the edge: state -> EMPTY, occupancy -> 0, and CTRL bits are cleared.
  - Any in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle counts as delivered.
  - in_ready the cycle after flush = 1.
- Occupancy: EMPTY=0, BUSY=1, FULL=2.
- Assertions for verification:
  - in_data is not required stable while !in_ready.
  - out_data/out_valid are stable while out_valid & !out_ready. The stage guarantees this.

Test Plan:
- Reset then stream: reset 2 cycles, then in_data=0x10,0x11,0x12 on consecutive cycles, out_ready=1 -> out_data 0x10,0x11,0x12 on cycles +1..+3, in_ready=1 throughout, occupancy=1.
- Backpressure (SKID=1): send 0xA0,0xA1,0xA2 with out_ready=0 -> 0xA0 in main, 0xA1 in skid, occupancy=2, in_ready=0, 0xA2 held upstream. Raise out_ready -> outputs 0xA0,0xA1,0xA2 in order, none lost.
- Bubble clearing (DATA_W=64, CTRL_W=8): send 0xDEAD_00FF, then drain with in_valid=0 -> out_valid=0 and out_data=0xDEAD_0000 the next cycle.
- Flush mid-stall: occupancy=2 (0xB0,0xB1), assert flush with in_valid=1 and in_data=0xB2 -> next cycle occupancy=0, out_valid=0, 0xB2 never appears, in_ready=1.
- SKID=0 mode: out_ready=0 with main full -> in_ready=0 in the same cycle. Raise out_ready -> in_ready=1 combinationally, and a simultaneous in/out fire keeps occupancy=1.
- Reset mid-operation: occupancy=2, assert reset 1 cycle with out_ready=1 -> out_valid=0, out_data=0, in_ready=0 during reset, in_ready=1 the following cycle.
